instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch-side initiator for the combinational instruction ROM. Holds the fetch PC, drives the ROM address, captures the returned word with its PC into a small prefetch FIFO, and delivers {pc, instr} to decode over a valid/ready handshake. Supports redirect (branch/jump) with flush, and a fetch-enable for halting.

Parameters:
ADDR_WIDTH, 8, ROM word-address width; PC width.
DATA_WIDTH, 32, instruction width.
FIFO_DEPTH, 2, prefetch entries; power of two, >= 2.
RESET_PC, 0, fetch PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
rom_addr  out  ADDR_WIDTH  ROM address; equals fetch_pc register (no combinational path from inputs).
rom_instr  in  DATA_WIDTH  ROM data; combinational response to rom_addr, valid same cycle.
fetch_en  in  1  1 = fetch allowed; 0 = hold fetch_pc, no pushes; FIFO still drains.
redirect_valid  in  1  1-cycle pulse: discard prefetched words, refetch from redirect_pc.
redirect_pc  in  ADDR_WIDTH  redirect target.
out_valid  out  1  FIFO head valid.
out_ready  in  1  decode accepts head.
out_instr  out  DATA_WIDTH  head instruction.
out_pc  out  ADDR_WIDTH  head PC.

Behaviour:
- Reset (async assert, sync-safe release): fetch_pc=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0. Asserting reset mid-operation clears immediately, without waiting for clk.
- push = fetch_en & ~redirect_valid & (~full | pop). pop = out_valid & out_ready.
- On push: FIFO writes {fetch_pc, rom_instr}; fetch_pc <= fetch_pc + 1, modulo 2^ADDR_WIDTH (0xFF -> 0x00 at default).
- Latency: word at PC X pushed in cycle t is visible at out_* with out_valid=1 in cycle t+1. Steady state with out_ready=1: one instruction per cycle.
- out_* are registered FIFO head outputs. They hold stable while out_valid=1 and out_ready=0. When the FIFO is empty, out_instr/out_pc keep their last value.
- Full with simultaneous pop: push allowed, occupancy unchanged.
- Empty: pop impossible, since out_valid=0.
- Redirect cycle:
  - A pop in the same cycle completes; decode has consumed that word.
  - All remaining entries are flushed, with no push.
  - fetch_pc <= redirect_pc.
  - Next cycle: out_valid=0, rom_addr=redirect_pc, and the push of redirect_pc proceeds if fetch_en=1.
  - First redirected word appears at out_* 2 cycles after the redirect cycle.
- Back-to-back redirects: the last one wins; each flushes.
- fetch_en=0 with redirect: redirect still updates fetch_pc and flushes.
- No X-propagation: rom_instr is sampled only on push.

Decomposition:
- Package fetch_pkg: ADDR_WIDTH/DATA_WIDTH defaults, RESET_PC, and the fetch-entry struct {pc, instr} typedef.
- Sub-module fetch_fifo: parameterised synchronous FIFO with registered head outputs, flush input, and full/empty. Pointers are log2(FIFO_DEPTH)+1 bits, wrap-bit full detection.
- Top-level instr_fetch holds the PC register and push/pop/redirect control.

Test Plan:
- Reset, then release with ROM[0..3]=0xA0..0xA3, out_ready=1, fetch_en=1 -> out_valid rises one cycle after release; out_pc 0,1,2,3 on consecutive cycles with out_instr 0xA0..0xA3.
- Backpressure: out_ready=0 for 5 cycles -> FIFO fills to 2; rom_addr holds at 2; out_pc=0 stable. Raise out_ready -> PCs 0,1,2,3 delivered with no loss or duplicate.
- Redirect to 0x40 while full and out_ready=1 -> head PC accepted that cycle; next cycle out_valid=0; following cycle out_pc=0x40, out_instr=ROM[0x40]; stale PCs never appear.
- Wrap: redirect to 0xFF -> out_pc sequence 0xFF, 0x00, 0x01.
- fetch_en=0 for 3 cycles mid-stream -> FIFO drains; rom_addr frozen; no pushes. Re-enable -> sequence resumes at frozen PC.
- Async reset asserted mid-stream, between clock edges -> out_valid=0 and rom_addr=RESET_PC immediately; after release the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and types for the instruction fetch unit.
//   ADDR_WIDTH - ROM word-address / PC width
//   DATA_WIDTH - instruction width
//   RESET_PC   - fetch PC loaded while reset is asserted
//   fetch_entry_t - one prefetch FIFO entry {pc, instr} at the default widths
package fetch_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with a registered head word and a flush input.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i, wdata_i - write request and data (ignored while flush_i is high)
//   pop_i           - remove the head entry (caller only pops when non-empty)
//   flush_i         - empty the FIFO; an accompanying pop is simply absorbed
//   full_o, empty_o - occupancy flags from the pointer registers
//   head_data_o     - registered copy of the head entry; keeps its last value
//                     while the FIFO is empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o     = (wr_q == rd_q);
    assign full_o      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_data_o = head_q;

    // The head register is loaded with whatever entry will sit at rd_d after
    // this edge. If that slot is the one being written now, forward wdata_i.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        head_d = head_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PTR_ONE;
            if (pop_i)  rd_d = rd_q + PTR_ONE;
            if (rd_d != wr_d) begin
                if (push_i && (wr_q[AW-1:0] == rd_d[AW-1:0]))
                    head_d = wdata_i;
                else
                    head_d = mem_q[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
            if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch-side initiator for a combinational instruction ROM.
//   clk, rst_n      - clock, asynchronous active-low reset
//   rom_addr        - ROM address, driven straight from the fetch PC register
//   rom_instr       - ROM data for rom_addr, same cycle
//   fetch_en        - 1 allows fetching; 0 freezes the PC (FIFO still drains)
//   redirect_valid  - one-cycle pulse: flush prefetched words, fetch redirect_pc
//   redirect_pc     - redirect target
//   out_valid/out_ready - valid/ready handshake to decode
//   out_instr/out_pc    - registered head of the prefetch FIFO
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both 1; out_valid never depends on out_ready and out_* stay stable while
// out_valid=1 and out_ready=0.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = fetch_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH = fetch_pkg::DATA_WIDTH,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_instr,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  push, pop, full, empty;
    logic [EW-1:0]         head;

    assign pop  = out_valid & out_ready;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign push = fetch_en & ~redirect_valid & (~full | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc;
        else if (push)
            pc_d = pc_q + PC_ONE;   // wraps modulo 2^ADDR_WIDTH
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (push),
        .wdata_i     ({pc_q, rom_instr}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .full_o      (full),
        .empty_o     (empty),
        .head_data_o (head)
    );

    assign rom_addr  = pc_q;
    assign out_valid = ~empty;
    assign out_pc    = head[EW-1:DATA_WIDTH];
    assign out_instr = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // ROM model: words 0..3 are 0xA0..0xA3, everything else tagged with its address.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    if (a < 8'd4) return 32'h0000_00A0 + {24'h0, a};
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  always_comb rom_instr = rom_word(rom_addr);

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Check a delivered head word: valid, PC and ROM contents for that PC.
  task automatic chk_head(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, {63'h0, out_valid}, 64'h1);
    chk({tag, "_pc"},    {56'h0, out_pc},    {56'h0, pc});
    chk({tag, "_instr"}, {32'h0, out_instr}, {32'h0, rom_word(pc)});
  endtask

  task automatic redirect(input logic [7:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    out_ready      = 1'b1;
    step();
    step();
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_addr",  {56'h0, rom_addr},  64'h0);
    chk("rst_pc",    {56'h0, out_pc},    64'h0);
    chk("rst_instr", {32'h0, out_instr}, 64'h0);

    // Release between edges; first word visible one cycle later.
    rst_n = 1'b1;
    chk("rel_valid0", {63'h0, out_valid}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_head("stream", 8'(i));
    end
    // Now head=3, one entry, PC=4.

    // Backpressure: FIFO fills with 3,4, PC stops at 5.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_head("bp_hold", 8'h03);
    chk("bp_addr", {56'h0, rom_addr}, 64'h05);
    out_ready = 1'b1;
    step(); chk_head("bp_rel4", 8'h04);
    step(); chk_head("bp_rel5", 8'h05);
    step(); chk_head("bp_rel6", 8'h06);
    // FIFO holds 6,7 (full), PC=8.

    // Redirect while full with pop: head 6 consumed, 7 flushed.
    redirect(8'h40);
    chk("rd_valid0", {63'h0, out_valid}, 64'h0);
    chk("rd_addr",   {56'h0, rom_addr},  64'h40);
    step(); chk_head("rd_first", 8'h40);
    step(); chk_head("rd_second", 8'h41);

    // PC wrap 0xFF -> 0x00.
    redirect(8'hFF);
    chk("wrap_valid0", {63'h0, out_valid}, 64'h0);
    step(); chk_head("wrap_ff", 8'hFF);
    step(); chk_head("wrap_00", 8'h00);
    step(); chk_head("wrap_01", 8'h01);

    // fetch_en low: FIFO drains, PC frozen at 2, head keeps last value.
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_valid", {63'h0, out_valid}, 64'h0);
      chk("halt_addr",  {56'h0, rom_addr},  64'h02);
    end
    chk("halt_keep_pc", {56'h0, out_pc}, 64'h01);
    fetch_en = 1'b1;
    step(); chk_head("resume_02", 8'h02);
    step(); chk_head("resume_03", 8'h03);

    // Redirect with fetch_en low still moves the PC and flushes.
    fetch_en = 1'b0;
    redirect(8'h10);
    chk("rdoff_valid", {63'h0, out_valid}, 64'h0);
    chk("rdoff_addr",  {56'h0, rom_addr},  64'h10);
    step();
    chk("rdoff_hold",  {63'h0, out_valid}, 64'h0);
    fetch_en = 1'b1;
    step(); chk_head("rdoff_10", 8'h10);

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 8'h20;
    step();
    redirect_pc    = 8'h30;
    step();
    redirect_valid = 1'b0;
    chk("b2b_valid0", {63'h0, out_valid}, 64'h0);
    chk("b2b_addr",   {56'h0, rom_addr},  64'h30);
    step(); chk_head("b2b_30", 8'h30);
    step(); chk_head("b2b_31", 8'h31);

    // Asynchronous reset between edges clears immediately.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'h0, out_valid}, 64'h0);
    chk("arst_addr",  {56'h0, rom_addr},  64'h0);
    chk("arst_pc",    {56'h0, out_pc},    64'h0);
    step();
    rst_n = 1'b1;
    step(); chk_head("arst_re0", 8'h00);
    step(); chk_head("arst_re1", 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
